// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register and divide sequencing controller:
// request opcodes, controller states and divider iteration count.
package hilo_pkg;

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpMthi = 2'b01;
  localparam logic [1:0] OpMtlo = 2'b10;
  localparam logic [1:0] OpRsvd = 2'b11;

  localparam int unsigned DIV_ITER = 32;
  localparam logic [5:0]  CntLoad  = 6'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StCapture
  } hilo_state_e;

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO controller: MTHI/MTLO writes and 33-edge DIV sequencing to an external divider.
// Optional macro HILO_DIVZ_CHECK_EN enables local divide-by-zero trapping.
module hilo_ctrl
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  hilo_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic        div_start_q, div_start_d;
  logic        done_q, done_d;
  logic        accept, divz_hit;

  assign accept = req_valid && (state_q == StIdle);

`ifdef HILO_DIVZ_CHECK_EN
  logic divz_q, divz_d;

  assign divz_hit     = (op_b == 32'd0);
  assign divz_d       = accept && (req_op == OpDiv) && divz_hit;
  assign div_zero_exc = divz_q;

  always_ff @(posedge clk) begin
    if (reset) divz_q <= 1'b0;
    else       divz_q <= divz_d;
  end
`else
  // The divider's own div_zero flag is sticky, so zero divisors simply run through.
  assign divz_hit     = 1'b0;
  assign div_zero_exc = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    div_start_d = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (req_op)
            OpDiv: begin
              if (!divz_hit) begin
                div_a_d     = op_a;
                div_b_d     = op_b;
                div_start_d = 1'b1;
                state_d     = StStart;
              end
            end
            OpMthi:  hi_d = op_a;
            OpMtlo:  lo_d = op_a;
            default: ;
          endcase
        end
      end
      StStart: begin
        cnt_d   = CntLoad;
        state_d = StWait;
      end
      StWait: begin
        // Leaving at the edge where the count reaches zero keeps accept-to-commit at 33 edges.
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = StCapture;
      end
      StCapture: begin
        hi_d    = div_hi;
        lo_d    = div_lo;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      div_a_q     <= 32'd0;
      div_b_q     <= 32'd0;
      div_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      div_start_q <= div_start_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign req_ready = ~busy;
  assign done      = done_q;
  assign div_start = div_start_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: directed scenarios plus random traffic against a
// countdown-based transaction model; a stand-in divider answers div_start.
module tb_hilo_ctrl;
  import hilo_pkg::*;

`ifdef HILO_DIVZ_CHECK_EN
  localparam bit DivzEn = 1'b1;
`else
  localparam bit DivzEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] op_a = '0, op_b = '0;
  logic        req_ready, busy, done, div_zero_exc, div_start;
  logic [31:0] div_a, div_b, div_hi, div_lo, hi, lo;

  always #5 clk = ~clk;

  hilo_ctrl u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .op_a         (op_a),
    .op_b         (op_b),
    .req_ready    (req_ready),
    .busy         (busy),
    .done         (done),
    .div_zero_exc (div_zero_exc),
    .div_start    (div_start),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_hi       (div_hi),
    .div_lo       (div_lo),
    .hi           (hi),
    .lo           (lo)
  );

  // Divider stand-in: captures operands on div_start, answers combinationally.
  logic [31:0] dv_a_q = '0, dv_b_q = '0;
  always @(posedge clk) if (div_start) begin
    dv_a_q <= div_a;
    dv_b_q <= div_b;
  end
  assign div_hi = (dv_b_q == 0) ? dv_a_q : dv_a_q % dv_b_q;
  assign div_lo = (dv_b_q == 0) ? 32'hFFFF_FFFF : dv_a_q / dv_b_q;

  // Transaction model: a DIV occupies the next 33 edges and commits on the last one.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_da = '0, m_db = '0, m_phi = '0, m_plo = '0;
  bit          m_done = 0, m_divz = 0, m_start = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit vld, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    m_done  = 0;
    m_divz  = 0;
    m_start = 0;
    if (rst) begin
      m_left = 0;
      m_hi = '0; m_lo = '0; m_da = '0; m_db = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi   = m_phi;
        m_lo   = m_plo;
        m_done = 1;
      end
    end else if (vld) begin
      case (op)
        2'b00: begin
          if (DivzEn && b == 0) begin
            m_divz = 1;
          end else begin
            m_da    = a;
            m_db    = b;
            m_left  = DIV_ITER + 1;
            m_start = 1;
            m_phi   = (b == 0) ? a : a % b;
            m_plo   = (b == 0) ? 32'hFFFF_FFFF : a / b;
          end
        end
        2'b01:   m_hi = a;
        2'b10:   m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check_eq("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check_eq("req_ready", {31'd0, req_ready}, {31'd0, m_left == 0});
    check_eq("done", {31'd0, done}, {31'd0, m_done});
    check_eq("div_zero_exc", {31'd0, div_zero_exc}, {31'd0, m_divz});
    check_eq("div_start", {31'd0, div_start}, {31'd0, m_start});
    check_eq("div_a", div_a, m_da);
    check_eq("div_b", div_b, m_db);
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
  endtask

  task automatic step(input bit rst, input bit vld, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    reset     = rst;
    req_valid = vld;
    req_op    = op;
    op_a      = a;
    op_b      = b;
    @(posedge clk);
    model_edge(rst, vld, op, a, b);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, $urandom, $urandom);
  endtask

  initial begin
    step(1, 1, OpMthi, 32'h1111_1111, 32'd0);
    step(1, 0, OpDiv, 32'd0, 32'd0);

    // DIV 7/2
    step(0, 1, OpDiv, 32'd7, 32'd2);
    idle(DIV_ITER + 1);
    check_eq("div7_2_hi", hi, 32'd1);
    check_eq("div7_2_lo", lo, 32'd3);
    idle(2);

    // DIV 100/7 with MTHI held throughout
    step(0, 1, OpDiv, 32'd100, 32'd7);
    for (int i = 0; i < DIV_ITER + 1; i++) step(0, 1, OpMthi, 32'hAAAA_5555, 32'd0);
    check_eq("div100_7_hi", hi, 32'd2);
    check_eq("div100_7_lo", lo, 32'd14);
    step(0, 1, OpMthi, 32'hAAAA_5555, 32'd0);
    check_eq("mthi_after_div", hi, 32'hAAAA_5555);
    idle(1);

    // DIV 10/0
    step(0, 1, OpDiv, 32'd10, 32'd0);
    idle(DIV_ITER + 2);

    // MTHI / MTLO back to back
    step(0, 1, OpMthi, 32'hDEAD_BEEF, 32'd0);
    step(0, 1, OpMtlo, 32'h1234_5678, 32'd0);
    check_eq("mthi_val", hi, 32'hDEAD_BEEF);
    check_eq("mtlo_val", lo, 32'h1234_5678);

    // Reserved opcode
    step(0, 1, OpRsvd, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(1);

    // DIV 50/5 killed by reset with the counter at 10, then DIV 9/3
    step(0, 1, OpDiv, 32'd50, 32'd5);
    idle(22);
    step(1, 1, OpDiv, 32'd8, 32'd2);
    check_eq("reset_mid_hi", hi, 32'd0);
    check_eq("reset_mid_lo", lo, 32'd0);
    idle(2);
    step(0, 1, OpDiv, 32'd9, 32'd3);
    idle(DIV_ITER + 1);
    check_eq("div9_3_hi", hi, 32'd0);
    check_eq("div9_3_lo", lo, 32'd3);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      bit          r, v;
      logic [1:0]  op;
      logic [31:0] a, b;
      r  = ($urandom_range(0, 199) == 0);
      v  = $urandom_range(0, 1) == 1;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      step(r, v, op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high, and clock clk.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- req_valid  in  1  CPU request strobe
- req_op  in  2  00 DIV, 01 MTHI, 10 MTLO, 11 reserved (ignored)
- op_a  in  32  dividend / MTHI-MTLO data
- op_b  in  32  divisor
- req_ready  out  1  high when IDLE
- busy  out  1  high in START/WAIT/CAPTURE; CPU stalls on it
- done  out  1  one-cycle pulse, DIV result committed
- div_zero_exc  out  1  one-cycle pulse, DIV with op_b==0
- div_start  out  1  registered start pulse to divider
- div_a, div_b  out  32  operands latched at accept
- div_hi, div_lo  in  32  divider remainder / quotient
- hi, lo  out  32  architectural HI/LO registers

Function
REQ-003 The block SHALL implement states IDLE, START, WAIT, CAPTURE.
REQ-004 A request SHALL be accepted only on an edge where req_valid=1 and state=IDLE; req_valid in any other state SHALL be ignored with no effect.
REQ-005 An accepted MTHI/MTLO SHALL write op_a into hi/lo on the accepting edge, with no busy, done or state change.
REQ-006 An accepted DIV at edge E0 SHALL latch div_a=op_a and div_b=op_b, enter START, and drive div_start=1 for exactly cycle E0-E1.
REQ-007 On edge E1 the block SHALL enter WAIT with a 6-bit counter loaded to 31, decremented once per edge; at counter 0 it SHALL enter CAPTURE on E32 (divider's 32 iterations occupy edges E1..E32).
REQ-008 On E33 the block SHALL copy div_hi→hi and div_lo→lo, drive done=1 for cycle E33-E34 only, and return to IDLE.
REQ-009 Total DIV latency SHALL be 33 edges from accept to commit; hi/lo SHALL hold their previous values until E33.
REQ-010 busy SHALL equal (state≠IDLE); req_ready SHALL equal ~busy.
REQ-011 div_start SHALL never be high outside START, and never for two consecutive cycles.
REQ-012 The divider's div_zero output SHALL NOT be used (sticky, not reset-cleared); zero detection SHALL be local, per Configuration.
REQ-013 A reserved op SHALL be accepted and dropped: no state change, no output pulse.

Reset
REQ-014 Reset SHALL force state=IDLE, counter=0, hi=lo=0, div_a=div_b=0, div_start=done=div_zero_exc=0, busy=0, req_ready=1.
REQ-015 Reset SHALL take priority over every other event, including mid-DIV (START/WAIT/CAPTURE); the in-flight result SHALL be discarded and done SHALL NOT pulse.
REQ-016 req_valid coincident with reset SHALL be ignored.

Configuration
REQ-017 Macro HILO_DIVZ_CHECK_EN defined: a DIV accepted with op_b==0 SHALL stay in IDLE, pulse div_zero_exc for cycle E0-E1, not assert div_start or done, and leave hi/lo unchanged.
REQ-018 Macro HILO_DIVZ_CHECK_EN undefined: op_b==0 SHALL be processed as a normal DIV; div_zero_exc SHALL be tied 0; hi/lo SHALL be committed at E33 with whatever the divider presents.

Structure
REQ-019 Package hilo_pkg SHALL hold the req_op encodings, the state enum, and constant DIV_ITER=32 (counter load = DIV_ITER-1).
REQ-020 The block SHALL be flat with no sub-module; the divider is instantiated by the parent datapath, not inside hilo_ctrl.

Verification
REQ-021 DIV 7/2 accepted at E0 -> div_start high E0-E1, busy E0-E33, done pulse E33-E34, hi=1, lo=3.
REQ-022 DIV 100/7 with req_valid held high and MTHI op throughout -> MTHI ignored while busy; hi=2, lo=14 at E33; MTHI accepted on first IDLE edge.
REQ-023 DIV 10/0, macro defined -> div_zero_exc pulse E0-E1, div_start never high, hi/lo unchanged, req_ready stays 1.
REQ-024 MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive edges -> hi=0xDEADBEEF, lo=0x12345678, busy never high.
REQ-025 DIV 50/5, reset asserted at counter=10 -> next edge IDLE, hi=lo=0, done never pulses; new DIV 9/3 then commits hi=0, lo=3 after 33 edges.
REQ-026 req_op=11 with req_valid=1 in IDLE -> no output change, state stays IDLE.
